// File: rtl/vga_scan_color_seq_if.sv
// ---------------------------------------------------------------------------
// vga_scan_color_seq_if
//   Control and video bus between a controller (master) and the VGA scan /
//   colour sequencer (slave).
//   Controller -> sequencer : en, auto_mode, step
//   Sequencer  -> controller: pix_x, pix_y, video_on, frame_tick, color_idx,
//                             color_onehot, hsync, vsync
// ---------------------------------------------------------------------------
interface vga_scan_color_seq_if #(
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int NCOLORS = 8
);
    localparam int CW = (NCOLORS > 1) ? $clog2(NCOLORS) : 1;

    logic               en;
    logic               auto_mode;
    logic               step;
    logic [XW-1:0]      pix_x;
    logic [YW-1:0]      pix_y;
    logic               video_on;
    logic               frame_tick;
    logic [CW-1:0]      color_idx;
    logic [NCOLORS-1:0] color_onehot;
    logic               hsync;
    logic               vsync;

    modport master (
        output en, auto_mode, step,
        input  pix_x, pix_y, video_on, frame_tick, color_idx, color_onehot,
               hsync, vsync
    );

    modport slave (
        input  en, auto_mode, step,
        output pix_x, pix_y, video_on, frame_tick, color_idx, color_onehot,
               hsync, vsync
    );
endinterface

// File: rtl/vga_scan_color_seq.sv
// ---------------------------------------------------------------------------
// vga_scan_color_seq
//   VGA raster scan generator with a frame-timed colour sequencer. The colour
//   index advances every DWELL_FRAMES frames in auto mode, or on each step
//   pulse in either running mode.
//
//   Ports
//     clk      : pixel clock
//     reset_n  : asynchronous active-low reset
//     bus      : vga_scan_color_seq_if.slave
//                in : en, auto_mode, step
//                out: pix_x, pix_y, video_on (comb), frame_tick, color_idx,
//                     color_onehot, hsync, vsync (active low)
//
//   Optional feature macro: VGA_SYNC_OUT_EN
//     defined   : registered hsync/vsync from the porch/width parameters
//                 (H_FP, H_SW, V_FP, V_SW exist only in this build)
//     undefined : hsync = vsync = 1, no sync logic
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | en low: counters, colour and dwell frozen, no frame_tick
//   AUTO    | scanning; colour advances on dwell expiry or step
//   MANUAL  | scanning; colour advances on step only, dwell held at 0
// ---------------------------------------------------------------------------
module vga_scan_color_seq #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int XW           = 10,
    parameter int YW           = 10,
    parameter int NCOLORS      = 8,
    parameter int DWELL_FRAMES = 60
`ifdef VGA_SYNC_OUT_EN
    ,
    parameter int H_FP         = 16,
    parameter int H_SW         = 96,
    parameter int V_FP         = 10,
    parameter int V_SW         = 2
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vga_scan_color_seq_if.slave   bus
);

    localparam int CW = (NCOLORS > 1) ? $clog2(NCOLORS) : 1;
    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACTIVE = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACTIVE = YW'(V_ACTIVE);
    localparam logic [CW-1:0] C_LAST   = CW'(NCOLORS - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_AUTO   = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       pix_x_q, pix_x_d;
    logic [YW-1:0]       pix_y_q, pix_y_d;
    logic                frame_tick_q, frame_tick_d;
    logic [CW-1:0]       color_q, color_d;
    logic [NCOLORS-1:0]  onehot_q, onehot_d;
    logic [DW-1:0]       dwell_q, dwell_d;

    logic run;
    logic x_wrap;
    logic y_wrap;
    logic dwell_expire;
    logic advance;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frame_tick_q <= 1'b0;
            color_q      <= '0;
            onehot_q     <= {{(NCOLORS-1){1'b0}}, 1'b1};
            dwell_q      <= '0;
        end else begin
            state_q      <= state_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            frame_tick_q <= frame_tick_d;
            color_q      <= color_d;
            onehot_q     <= onehot_d;
            dwell_q      <= dwell_d;
        end
    end

    // The mode for this cycle is the next state, so a change on en or
    // auto_mode takes effect on the very edge it is sampled.
    always_comb begin
        state_d      = state_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_tick_d = 1'b0;
        color_d      = color_q;
        dwell_d      = dwell_q;
        run          = 1'b0;
        dwell_expire = 1'b0;
        advance      = 1'b0;
        x_wrap       = (pix_x_q == X_LAST);
        y_wrap       = (pix_y_q == Y_LAST);

        case (state_q)
            ST_IDLE: begin
                if (bus.en) state_d = bus.auto_mode ? ST_AUTO : ST_MANUAL;
            end
            ST_AUTO: begin
                if (!bus.en)             state_d = ST_IDLE;
                else if (!bus.auto_mode) state_d = ST_MANUAL;
            end
            ST_MANUAL: begin
                if (!bus.en)            state_d = ST_IDLE;
                else if (bus.auto_mode) state_d = ST_AUTO;
            end
            default: state_d = ST_IDLE;
        endcase

        run = (state_d != ST_IDLE);

        if (run) begin
            if (x_wrap) begin
                pix_x_d = '0;
                pix_y_d = y_wrap ? '0 : pix_y_q + YW'(1);
            end else begin
                pix_x_d = pix_x_q + XW'(1);
            end
            frame_tick_d = x_wrap && y_wrap;
        end

        // Step and dwell expiry in the same cycle merge into one advance.
        dwell_expire = (state_d == ST_AUTO) && frame_tick_q && (dwell_q == D_LAST);
        advance      = (run && bus.step) || dwell_expire;

        case (state_d)
            ST_AUTO: begin
                if (advance)           dwell_d = '0;
                else if (frame_tick_q) dwell_d = dwell_q + DW'(1);
            end
            ST_MANUAL: dwell_d = '0;
            default:   dwell_d = dwell_q;
        endcase

        if (advance) color_d = (color_q == C_LAST) ? '0 : color_q + CW'(1);
    end

    // One-hot is built from the next index so both registers update together.
    assign onehot_d = {{(NCOLORS-1){1'b0}}, 1'b1} << color_d;

    assign bus.pix_x        = pix_x_q;
    assign bus.pix_y        = pix_y_q;
    assign bus.frame_tick   = frame_tick_q;
    assign bus.color_idx    = color_q;
    assign bus.color_onehot = onehot_q;
    assign bus.video_on     = bus.en && (pix_x_q < X_ACTIVE) && (pix_y_q < Y_ACTIVE);

`ifdef VGA_SYNC_OUT_EN
    logic hsync_q;
    logic vsync_q;
    logic hs_lo;
    logic vs_lo;

    assign hs_lo = (int'(pix_x_q) >= H_ACTIVE + H_FP) &&
                   (int'(pix_x_q) <  H_ACTIVE + H_FP + H_SW);
    assign vs_lo = (int'(pix_y_q) >= V_ACTIVE + V_FP) &&
                   (int'(pix_y_q) <  V_ACTIVE + V_FP + V_SW);

    // Decoded from the current counters, so syncs trail them by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else if (bus.en) begin
            hsync_q <= ~hs_lo;
            vsync_q <= ~vs_lo;
        end
    end

    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;
`else
    assign bus.hsync = 1'b1;
    assign bus.vsync = 1'b1;
`endif

endmodule

// File: tb/tb_vga_scan_color_seq.sv
module tb_vga_scan_color_seq;

    localparam int H_TOTAL  = 10;
    localparam int V_TOTAL  = 4;
    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 3;
    localparam int NCOLORS  = 8;
    localparam int DWELL    = 2;
    localparam int NPIX     = H_TOTAL * V_TOTAL;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_scan_color_seq_if #(.XW(10), .YW(10), .NCOLORS(NCOLORS)) bus ();

    vga_scan_color_seq #(
        .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .XW(10), .YW(10), .NCOLORS(NCOLORS), .DWELL_FRAMES(DWELL)
`ifdef VGA_SYNC_OUT_EN
        , .H_FP(1), .H_SW(1), .V_FP(0), .V_SW(1)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int x;
        int y;
        bit tick;
        int color;
        bit video;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: raster position as a single linear index within the
    // frame, colour and frames-since-last-advance as plain integers.
    int m_pos, m_color, m_frames;
    bit m_tick;

    task automatic model_reset();
        m_pos = 0; m_color = 0; m_frames = 0; m_tick = 0;
    endtask

    task automatic model_edge(input bit en_v, input bit am_v, input bit st_v);
        bit adv;
        if (!en_v) begin
            m_tick = 0;
            return;
        end
        adv = st_v || (am_v && m_tick && (m_frames == DWELL - 1));
        if (!am_v || adv) m_frames = 0;
        else if (m_tick)  m_frames = m_frames + 1;
        if (adv) m_color = (m_color + 1) % NCOLORS;
        m_tick = (m_pos == NPIX - 1);
        m_pos  = (m_pos + 1) % NPIX;
    endtask

    task automatic push_expected(input bit en_v);
        exp_t e;
        e.x     = m_pos % H_TOTAL;
        e.y     = m_pos / H_TOTAL;
        e.tick  = m_tick;
        e.color = m_color;
        e.video = en_v && (e.x < H_ACTIVE) && (e.y < V_ACTIVE);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [NCOLORS-1:0] oh;
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.color] = 1'b1;
            check("pix_x",        int'(bus.pix_x),        e.x);
            check("pix_y",        int'(bus.pix_y),        e.y);
            check("frame_tick",   int'(bus.frame_tick),   int'(e.tick));
            check("color_idx",    int'(bus.color_idx),    e.color);
            check("color_onehot", int'(bus.color_onehot), int'(oh));
            check("video_on",     int'(bus.video_on),     int'(e.video));
`ifndef VGA_SYNC_OUT_EN
            check("hsync", int'(bus.hsync), 1);
            check("vsync", int'(bus.vsync), 1);
`endif
        end
    end

    task automatic cycle(input bit en_v, input bit am_v, input bit st_v, input bit rst_v);
        @(negedge clk);
        #1;
        reset_n       = 1'b1;
        bus.en        = en_v;
        bus.auto_mode = am_v;
        bus.step      = st_v;
        @(posedge clk);
        model_edge(en_v, am_v, st_v);
        #1;
        if (rst_v) begin
            reset_n = 1'b0;
            model_reset();
        end
        push_expected(en_v);
    endtask

    initial begin
        bit am;
        bus.en        = 1'b0;
        bus.auto_mode = 1'b0;
        bus.step      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        push_expected(1'b0);

        // Plain scan, tick after 40 enabled clocks.
        repeat (45) cycle(1, 0, 0, 0);

        // Auto mode over a full colour cycle.
        repeat (16 * NPIX + 5) cycle(1, 1, 0, 0);

        // Manual steps, then several frames with no change.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 0);
            repeat (3) cycle(1, 0, 0, 0);
        end
        repeat (5 * NPIX) cycle(1, 0, 0, 0);

        // Auto with step coinciding with dwell expiry.
        for (int i = 0; i < 8 * NPIX; i++)
            cycle(1, 1, (m_tick && m_frames == DWELL - 1) ? 1'b1 : 1'b0, 0);

        // Freeze mid-line, then resume.
        repeat (4) cycle(1, 1, 0, 0);
        repeat (20) cycle(0, 1, 0, 0);
        repeat (12) cycle(1, 1, 0, 0);

        // Randomized mix of enable, mode changes and steps.
        am = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) am = ~am;
            cycle(($urandom_range(0, 9) != 0), am, ($urandom_range(0, 11) == 0), 0);
        end

        // Reset mid-frame with colour 5.
        while (m_color != 5) cycle(1, 0, 1, 0);
        repeat (13) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        repeat (15) cycle(1, 1, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
